// File: rtl/packet_dispatcher_pkg.sv
// Shared definitions for the packet dispatcher and its downstream router.
package packet_dispatcher_pkg;

  // Router FSM encodings.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FORWARD = 2'd1,
    ST_DROP    = 2'd2
  } router_state_t;

  // Default width of every statistics counter.
  localparam int DEFAULT_COUNTER_WIDTH = 32;

endpackage

// File: rtl/axis_dest_router_out_reg.sv
// Single-entry output register for the destination router.
// Holds one beat plus its target port; only tvalid is port-specific, the
// held data/keep/last are replicated onto every master slice.
module axis_dest_router_out_reg #(
  parameter int DATA_W  = 64,
  parameter int KEEP_W  = 8,
  parameter int SEL_W   = 2,
  parameter int M_COUNT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_load,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [KEEP_W-1:0]          in_keep,
  input  logic                       in_last,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic [M_COUNT-1:0]         m_axis_tready,
  output logic [M_COUNT*DATA_W-1:0]  m_axis_tdata,
  output logic [M_COUNT*KEEP_W-1:0]  m_axis_tkeep,
  output logic [M_COUNT-1:0]         m_axis_tvalid,
  output logic [M_COUNT-1:0]         m_axis_tlast,
  output logic                       can_accept,
  output logic                       pop_last,
  output logic [SEL_W-1:0]           out_sel
);

  logic              out_valid_r;
  logic [SEL_W-1:0]  out_sel_r;
  logic [DATA_W-1:0] out_data_r;
  logic [KEEP_W-1:0] out_keep_r;
  logic              out_last_r;
  logic              sel_ready_s;
  logic              pop_s;

  // A stalled selected port blocks the whole register (head-of-line blocking).
  assign sel_ready_s = m_axis_tready[out_sel_r];
  assign pop_s       = out_valid_r && sel_ready_s;
  assign can_accept  = !out_valid_r || sel_ready_s;
  assign pop_last    = pop_s && out_last_r;
  assign out_sel     = out_sel_r;

  assign m_axis_tdata = {M_COUNT{out_data_r}};
  assign m_axis_tkeep = {M_COUNT{out_keep_r}};
  assign m_axis_tlast = {M_COUNT{out_last_r}};

  // Decode the held selector into the per-port valid bits.
  always_comb begin
    m_axis_tvalid = {M_COUNT{1'b0}};
    for (int i = 0; i < M_COUNT; i++) begin
      if (out_valid_r && (out_sel_r == SEL_W'(i))) begin
        m_axis_tvalid[i] = 1'b1;
      end else begin
        m_axis_tvalid[i] = 1'b0;
      end
    end
  end

  // Load a new beat (possibly in the same cycle the old one leaves) or drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_sel_r   <= {SEL_W{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
      out_keep_r  <= {KEEP_W{1'b0}};
      out_last_r  <= 1'b0;
    end else if (in_load) begin
      out_valid_r <= 1'b1;
      out_sel_r   <= in_sel;
      out_data_r  <= in_data;
      out_keep_r  <= in_keep;
      out_last_r  <= in_last;
    end else if (pop_s) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_dest_router.sv
// AXI-Stream destination router: steers each packet to the master port named
// by tdest on its first beat, drains packets aimed at disabled ports, and keeps
// per-port forwarded-packet counters plus one drop counter.
module axis_dest_router
  import packet_dispatcher_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
  parameter int AXIS_DEST_WIDTH = 2,
  parameter int M_COUNT         = 2**AXIS_DEST_WIDTH,
  parameter int COUNTER_WIDTH   = DEFAULT_COUNTER_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]           s_axis_tkeep,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,
  input  logic [AXIS_DEST_WIDTH-1:0]           s_axis_tdest,
  output logic [M_COUNT*AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_COUNT*AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic [M_COUNT-1:0]                   m_axis_tvalid,
  input  logic [M_COUNT-1:0]                   m_axis_tready,
  output logic [M_COUNT-1:0]                   m_axis_tlast,
  input  logic [M_COUNT-1:0]                   port_enable,
  input  logic                                 rst_counters,
  output logic [M_COUNT*COUNTER_WIDTH-1:0]     pkt_count,
  output logic [COUNTER_WIDTH-1:0]             drop_count
);

  router_state_t                                state_r;
  logic [AXIS_DEST_WIDTH-1:0]                   sel_r;
  logic [M_COUNT-1:0][COUNTER_WIDTH-1:0]        pkt_cnt_r;
  logic [COUNTER_WIDTH-1:0]                     drop_cnt_r;

  logic                                         can_accept_s;
  logic                                         pop_last_s;
  logic [AXIS_DEST_WIDTH-1:0]                   out_sel_s;
  logic                                         accept_s;
  logic                                         dest_en_s;
  logic                                         load_s;
  logic [AXIS_DEST_WIDTH-1:0]                   load_sel_s;
  logic                                         drop_done_s;

  // DROP never waits on the output register; elsewhere the register gates input.
  assign s_axis_tready = !rst && ((state_r == ST_DROP) || can_accept_s);
  assign accept_s      = s_axis_tvalid && s_axis_tready;
  assign dest_en_s     = port_enable[s_axis_tdest];

  // Decide per accepted beat whether it is loaded, and whether a drop completes.
  always_comb begin
    load_s      = 1'b0;
    load_sel_s  = sel_r;
    drop_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        load_sel_s = s_axis_tdest;
        if (accept_s) begin
          load_s      = dest_en_s;
          drop_done_s = !dest_en_s && s_axis_tlast;
        end else begin
          load_s      = 1'b0;
          drop_done_s = 1'b0;
        end
      end
      ST_FORWARD: begin
        load_s = accept_s;
      end
      ST_DROP: begin
        if (accept_s && s_axis_tlast) begin
          drop_done_s = 1'b1;
        end else begin
          drop_done_s = 1'b0;
        end
      end
      default: begin
        load_s      = 1'b0;
        drop_done_s = 1'b0;
      end
    endcase
  end

  // Packet-level FSM; the selector is latched only on first beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sel_r   <= {AXIS_DEST_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            sel_r <= s_axis_tdest;
            if (s_axis_tlast) begin
              state_r <= ST_IDLE;
            end else if (dest_en_s) begin
              state_r <= ST_FORWARD;
            end else begin
              state_r <= ST_DROP;
            end
          end
        end
        ST_FORWARD, ST_DROP: begin
          if (accept_s && s_axis_tlast) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Statistics: clear has priority and swallows any same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < M_COUNT; i++) begin
        pkt_cnt_r[i] <= {COUNTER_WIDTH{1'b0}};
      end
      drop_cnt_r <= {COUNTER_WIDTH{1'b0}};
    end else if (rst_counters) begin
      for (int i = 0; i < M_COUNT; i++) begin
        pkt_cnt_r[i] <= {COUNTER_WIDTH{1'b0}};
      end
      drop_cnt_r <= {COUNTER_WIDTH{1'b0}};
    end else begin
      if (pop_last_s) begin
        pkt_cnt_r[out_sel_s] <= pkt_cnt_r[out_sel_s] + COUNTER_WIDTH'(1);
      end
      if (drop_done_s) begin
        drop_cnt_r <= drop_cnt_r + COUNTER_WIDTH'(1);
      end
    end
  end

  assign pkt_count  = pkt_cnt_r;
  assign drop_count = drop_cnt_r;

  axis_dest_router_out_reg #(
    .DATA_W  (AXIS_DATA_WIDTH),
    .KEEP_W  (AXIS_KEEP_WIDTH),
    .SEL_W   (AXIS_DEST_WIDTH),
    .M_COUNT (M_COUNT)
  ) u_out_reg (
    .clk           (clk),
    .rst           (rst),
    .in_load       (load_s),
    .in_data       (s_axis_tdata),
    .in_keep       (s_axis_tkeep),
    .in_last       (s_axis_tlast),
    .in_sel        (load_sel_s),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .can_accept    (can_accept_s),
    .pop_last      (pop_last_s),
    .out_sel       (out_sel_s)
  );

endmodule

// File: tb/tb_axis_dest_router.sv
// Directed self-checking bench for axis_dest_router (4 ports, 64-bit data).
module tb_axis_dest_router;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int TW = 2;
  localparam int MC = 4;
  localparam int CW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     s_axis_tdata;
  logic [KW-1:0]     s_axis_tkeep;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic [TW-1:0]     s_axis_tdest;
  logic [MC*DW-1:0]  m_axis_tdata;
  logic [MC*KW-1:0]  m_axis_tkeep;
  logic [MC-1:0]     m_axis_tvalid;
  logic [MC-1:0]     m_axis_tready;
  logic [MC-1:0]     m_axis_tlast;
  logic [MC-1:0]     port_enable;
  logic              rst_counters;
  logic [MC*CW-1:0]  pkt_count;
  logic [CW-1:0]     drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  axis_dest_router dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdest  (s_axis_tdest),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .port_enable   (port_enable),
    .rst_counters  (rst_counters),
    .pkt_count     (pkt_count),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one input beat at a falling edge.
  task automatic beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic [TW-1:0] t);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tdest  = t;
  endtask

  task automatic idle_in();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Check the single valid port, and its data/keep/last slices.
  task automatic expect_out(input string tag, input logic [MC-1:0] v, input int p,
                            input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    check({tag, "_valid"}, 64'(m_axis_tvalid), 64'(v));
    check({tag, "_data"},  m_axis_tdata[p*DW +: DW], d);
    check({tag, "_keep"},  64'(m_axis_tkeep[p*KW +: KW]), 64'(k));
    check({tag, "_last"},  64'(m_axis_tlast[p]), 64'(l));
  endtask

  function automatic logic [63:0] pc(input int p);
    return 64'(pkt_count[p*CW +: CW]);
  endfunction

  initial begin
    rst = 1'b1;
    s_axis_tdata = 64'd0; s_axis_tkeep = 8'd0; s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;  s_axis_tdest = 2'd0;
    m_axis_tready = 4'hF; port_enable = 4'hF; rst_counters = 1'b0;

    // Reset state
    @(negedge clk); #1;
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_pkt",    64'(pkt_count[63:0]) | 64'(pkt_count[127:64]), 64'd0);
    check("rst_drop",   64'(drop_count), 64'd0);
    @(negedge clk); rst = 1'b0;

    // 1: three-beat packet to port 2
    @(negedge clk); beat(64'hA0, 8'hFF, 1'b0, 2'd2); #1;
    check("t1_tready", 64'(s_axis_tready), 64'd1);
    check("t1_pre_valid", 64'(m_axis_tvalid), 64'd0);
    @(negedge clk); #1; expect_out("t1_b0", 4'b0100, 2, 64'hA0, 8'hFF, 1'b0);
    beat(64'hA1, 8'hFF, 1'b0, 2'd0);
    @(negedge clk); #1; expect_out("t1_b1", 4'b0100, 2, 64'hA1, 8'hFF, 1'b0);
    beat(64'hA2, 8'h0F, 1'b1, 2'd3);
    @(negedge clk); #1; expect_out("t1_b2", 4'b0100, 2, 64'hA2, 8'h0F, 1'b1);
    idle_in();
    @(negedge clk); #1;
    check("t1_idle_valid", 64'(m_axis_tvalid), 64'd0);
    check("t1_pkt2", pc(2), 64'd1);
    check("t1_pkt0", pc(0), 64'd0);

    // 2: four-beat packet to disabled port 1 is drained
    port_enable = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); beat(64'hB0 + 64'(i), 8'hFF, (i == 3), 2'd1); #1;
      check("t2_tready", 64'(s_axis_tready), 64'd1);
      check("t2_valid",  64'(m_axis_tvalid), 64'd0);
      check("t2_drop_pending", 64'(drop_count), 64'd0);
    end
    @(negedge clk); idle_in(); #1;
    check("t2_drop", 64'(drop_count), 64'd1);
    check("t2_valid_after", 64'(m_axis_tvalid), 64'd0);
    check("t2_pkt1", pc(1), 64'd0);

    // 3: back-to-back single-beat packets to ports 0,3,0
    port_enable = 4'hF;
    @(negedge clk); beat(64'hC0, 8'h01, 1'b1, 2'd0);
    @(negedge clk); #1; expect_out("t3_c0", 4'b0001, 0, 64'hC0, 8'h01, 1'b1);
    check("t3_tready0", 64'(s_axis_tready), 64'd1);
    beat(64'hC1, 8'h03, 1'b1, 2'd3);
    @(negedge clk); #1; expect_out("t3_c1", 4'b1000, 3, 64'hC1, 8'h03, 1'b1);
    beat(64'hC2, 8'h07, 1'b1, 2'd0);
    @(negedge clk); #1; expect_out("t3_c2", 4'b0001, 0, 64'hC2, 8'h07, 1'b1);
    idle_in();
    @(negedge clk); #1;
    check("t3_pkt0", pc(0), 64'd2);
    check("t3_pkt3", pc(3), 64'd1);
    check("t3_pkt2", pc(2), 64'd1);

    // 4: port 0 stalls for 5 cycles mid-packet; enable drop mid-packet is ignored
    @(negedge clk); beat(64'hD0, 8'hFF, 1'b0, 2'd0);
    @(negedge clk); m_axis_tready = 4'b1110; beat(64'hD1, 8'hFF, 1'b0, 2'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) port_enable = 4'b1110;
      #1;
      check("t4_stall_tready", 64'(s_axis_tready), 64'd0);
      expect_out("t4_stall", 4'b0001, 0, 64'hD0, 8'hFF, 1'b0);
      @(negedge clk);
    end
    m_axis_tready = 4'hF; #1;
    check("t4_resume_tready", 64'(s_axis_tready), 64'd1);
    @(negedge clk); #1; expect_out("t4_d1", 4'b0001, 0, 64'hD1, 8'hFF, 1'b0);
    beat(64'hD2, 8'h00, 1'b1, 2'd2);
    @(negedge clk); #1; expect_out("t4_d2", 4'b0001, 0, 64'hD2, 8'h00, 1'b1);
    idle_in(); port_enable = 4'hF;
    @(negedge clk); #1;
    check("t4_pkt0", pc(0), 64'd3);
    check("t4_valid", 64'(m_axis_tvalid), 64'd0);

    // 5: counter clear coincides with a tlast handshake on port 3
    @(negedge clk); beat(64'hE0, 8'hFF, 1'b1, 2'd3);
    @(negedge clk); idle_in(); rst_counters = 1'b1; #1;
    check("t5_valid", 64'(m_axis_tvalid), 64'b1000);
    @(negedge clk); rst_counters = 1'b0; #1;
    check("t5_pkt3", pc(3), 64'd0);
    check("t5_pkt0", pc(0), 64'd0);
    check("t5_drop", 64'(drop_count), 64'd0);

    // 6: reset mid-packet, then the next packet routes by its own tdest
    @(negedge clk); beat(64'hF0, 8'hFF, 1'b0, 2'd1);
    @(negedge clk); #1;
    check("t6_pre_valid", 64'(m_axis_tvalid), 64'b0010);
    idle_in(); rst = 1'b1; #1;
    check("t6_rst_valid", 64'(m_axis_tvalid), 64'd0);
    check("t6_rst_tready", 64'(s_axis_tready), 64'd0);
    @(negedge clk); rst = 1'b0; beat(64'hF5, 8'h00, 1'b1, 2'd2); #1;
    check("t6_tready", 64'(s_axis_tready), 64'd1);
    @(negedge clk); #1; expect_out("t6_next", 4'b0100, 2, 64'hF5, 8'h00, 1'b1);
    idle_in();
    @(negedge clk); #1;
    check("t6_pkt2", pc(2), 64'd1);
    check("t6_pkt1", pc(1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
